core_uart_ctrl: RTL and testbench
=================================

Name: core_uart_ctrl

Overview:
- Sequencing controller between the multicycle core's IN/OUT instructions and the AXI4-Lite UART slave.
- Core issues a single-byte read (IN) or write (OUT) request and stalls until a one-cycle response.
- Block runs the full status-poll, data-read and data-write AXI handshakes.
- Removes all bus sequencing from the core.

Parameters:
STAT_ADDR, 4'h8, AXI address of UART status register
RX_ADDR, 4'h0, AXI address of RX data register
TX_ADDR, 4'h4, AXI address of TX data register
RX_VALID_BIT, 0, status bit: 1 = RX byte available
TX_FULL_BIT, 3, status bit: 1 = TX FIFO full
POLL_MAX, 1023, status-poll limit (used only with UART_CTRL_TIMEOUT_EN)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
REQ_VALID  in  1  core request strobe
REQ_WRITE  in  1  1 = OUT (write byte), 0 = IN (read byte)
REQ_WDATA  in  8  byte to transmit
REQ_READY  out  1  controller idle, request accepted this cycle
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  8  received byte, valid with RSP_VALID on reads
RSP_ERR  out  1  nonzero RRESP/BRESP, or timeout
BUSY  out  1  transaction in flight (core stall source)
ARADDR  out  4  AXI read address
ARVALID  out  1
ARREADY  in  1
RDATA  in  32
RRESP  in  2
RVALID  in  1
RREADY  out  1
AWADDR  out  4
AWVALID  out  1
AWREADY  in  1
WDATA  out  32
WSTRB  out  4
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1

Behaviour:
- One clock CLK; RST synchronous, active-high.
- Reset values: all AXI valid/ready outputs 0; ARADDR, AWADDR, WDATA 0; WSTRB 4'b0001; RSP_VALID 0, RSP_RDATA 0, RSP_ERR 0; BUSY 0; state IDLE.
- All outputs are registered.
- REQ_READY = (state==IDLE). BUSY = (state!=IDLE).
- IDLE: REQ_VALID=1 latches REQ_WRITE/REQ_WDATA, clears err, goes to STAT_AR.
- STAT_AR: ARADDR=STAT_ADDR, ARVALID=1 held until sampled with ARREADY=1; then ARVALID=0, go to STAT_R.
- STAT_R: RREADY=1 until RVALID. On handshake:
  - RRESP!=0 -> err=1, go to DONE.
  - Read op: RDATA[RX_VALID_BIT]=1 -> DATA_AR, else back to STAT_AR (re-poll).
  - Write op: RDATA[TX_FULL_BIT]=1 -> STAT_AR, else WR_AW_W.
- DATA_AR: ARADDR=RX_ADDR, ARVALID=1 until ARREADY; then DATA_R.
- DATA_R: RREADY=1. On RVALID, capture RDATA[7:0] into RSP_RDATA; err = (RRESP!=0); go to DONE.
- WR_AW_W: AWADDR=TX_ADDR, WDATA={24'b0,byte}, WSTRB=4'b0001; AWVALID and WVALID asserted together.
  - Each drops independently on its own ready handshake; AW and W may complete in either order or in the same cycle.
  - Go to WR_B in the cycle after both are complete.
- WR_B: BREADY=1. On BVALID: err = (BRESP!=0); go to DONE.
- DONE: RSP_VALID=1 for exactly one cycle, RSP_ERR=err, then IDLE. Response has no backpressure.
- RSP_RDATA holds its last value until the next read completes. Write responses leave it unchanged.
- VALID signals never drop before their handshake; address/data stay stable while VALID=1 (AXI rule).
- A ready asserted in the same cycle VALID first rises counts as a handshake only when sampled with VALID=1.
- REQ_VALID while BUSY is ignored; the core holds it until REQ_READY.
- Minimum latencies with a zero-wait slave, from request-accept edge to RSP_VALID:
  - Read: 5 cycles.
  - Write: 5 cycles.
- Reset mid-transaction returns to IDLE next edge with all valids 0. The UART slave shares RST.

Optional Feature:
UART_CTRL_TIMEOUT_EN
- Defined:
  - 10-bit poll counter cleared on request accept; increments on each not-ready status response (RX empty or TX full).
  - When the counter reaches POLL_MAX on a not-ready response, go to DONE with RSP_ERR=1. On a read, RSP_RDATA=0.
- Undefined: no counter; polling continues indefinitely until the status bit is ready.

Test Plan:
- Read, status 0x1 then RDATA 0x41, zero-wait slave -> ARADDR 8 then 0, RSP_VALID pulse 5 cycles after accept, RSP_RDATA=0x41, RSP_ERR=0.
- Read, status 0x0 three times then 0x1, data 0x7F -> four status reads, one data read, RSP_RDATA=0x7F.
- Write 0x5A, status 0x8 twice then 0x0, AWREADY two cycles before WREADY -> AWVALID/WVALID drop independently, WDATA=0x0000005A, WSTRB=0001, one RSP_VALID, RSP_ERR=0.
- Write with BRESP=2'b10 -> RSP_VALID with RSP_ERR=1; next request accepted normally.
- RST asserted while in WR_AW_W with AWREADY=0 -> next cycle state IDLE, AWVALID=WVALID=0, REQ_READY=1, no RSP_VALID.
- With UART_CTRL_TIMEOUT_EN, POLL_MAX=4, status always 0x0 on read -> exactly 4 status reads, RSP_ERR=1, RSP_RDATA=0. Without the macro, polling continues past 4.

Source files
------------

// File: rtl/core_uart_ctrl_if.sv
// core_uart_ctrl_if: bundles the core request/response handshake and the AXI4-Lite
// master channels that core_uart_ctrl drives toward the UART slave.
// master: the controller side. slave: the core plus the UART, i.e. everything around it.
interface core_uart_ctrl_if;
    // Core request / response
    logic        REQ_VALID;
    logic        REQ_WRITE;
    logic [7:0]  REQ_WDATA;
    logic        REQ_READY;
    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic        RSP_ERR;
    logic        BUSY;
    // AXI4-Lite read channels
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    // AXI4-Lite write channels
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_WDATA,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID,
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_WDATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID,
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/core_uart_ctrl.sv
// core_uart_ctrl: turns a single-byte IN/OUT request from the core into the full
// AXI4-Lite sequence against the UART: poll status, then read RX data or write TX data,
// and return a one-cycle completion pulse. All outputs are registered.
// Optional feature macro: UART_CTRL_TIMEOUT_EN (bounds status polling to POLL_MAX tries).
module core_uart_ctrl #(
    parameter logic [3:0]  STAT_ADDR    = 4'h8,
    parameter logic [3:0]  RX_ADDR      = 4'h0,
    parameter logic [3:0]  TX_ADDR      = 4'h4,
    parameter int unsigned RX_VALID_BIT = 0,
    parameter int unsigned TX_FULL_BIT  = 3,
    parameter int unsigned POLL_MAX     = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    core_uart_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle, StStatAr, StStatR, StDataAr, StDataR, StWrAwW, StWrB, StDone
    } state_t;

    state_t      state_q;
    logic        is_write_q;
    logic [7:0]  wbyte_q;
    logic        err_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        req_ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;
    logic [3:0]  araddr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [3:0]  awaddr_q;
    logic        awvalid_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        wvalid_q;
    logic        bready_q;
`ifdef UART_CTRL_TIMEOUT_EN
    logic [9:0]  poll_cnt_q;
`endif

    logic status_ok;
    logic aw_fire;
    logic w_fire;
    logic unused_bits;

    // Status register says the requested direction can proceed
    assign status_ok = is_write_q ? ~bus.RDATA[TX_FULL_BIT] : bus.RDATA[RX_VALID_BIT];
    // A ready only counts while our valid is actually up
    assign aw_fire   = awvalid_q & bus.AWREADY;
    assign w_fire    = wvalid_q & bus.WREADY;
    assign unused_bits = ^{bus.RDATA[31:8], 10'(POLL_MAX)};

    // Single sequencing FSM; every bus output is a flop updated on the transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            is_write_q  <= 1'b0;
            wbyte_q     <= 8'h00;
            err_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            araddr_q    <= 4'h0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= 4'h0;
            awvalid_q   <= 1'b0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'b0001;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
            poll_cnt_q  <= 10'd0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.REQ_VALID) begin
                        is_write_q  <= bus.REQ_WRITE;
                        wbyte_q     <= bus.REQ_WDATA;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        araddr_q    <= STAT_ADDR;
                        arvalid_q   <= 1'b1;
`ifdef UART_CTRL_TIMEOUT_EN
                        poll_cnt_q  <= 10'd0;
`endif
                        state_q     <= StStatAr;
                    end
                end
                StStatAr: begin
                    if (bus.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StStatR;
                    end
                end
                StStatR: begin
                    if (bus.RVALID) begin
                        rready_q <= 1'b0;
                        if (bus.RRESP != 2'b00) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else if (status_ok) begin
                            if (is_write_q) begin
                                awaddr_q  <= TX_ADDR;
                                wdata_q   <= {24'h0, wbyte_q};
                                wstrb_q   <= 4'b0001;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                aw_done_q <= 1'b0;
                                w_done_q  <= 1'b0;
                                state_q   <= StWrAwW;
                            end else begin
                                araddr_q  <= RX_ADDR;
                                arvalid_q <= 1'b1;
                                state_q   <= StDataAr;
                            end
`ifdef UART_CTRL_TIMEOUT_EN
                        end else if (poll_cnt_q == 10'(POLL_MAX - 1)) begin
                            // This not-ready response is the POLL_MAX-th: give up
                            poll_cnt_q <= poll_cnt_q + 10'd1;
                            err_q      <= 1'b1;
                            if (!is_write_q) rsp_rdata_q <= 8'h00;
                            state_q    <= StDone;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 10'd1;
                            araddr_q   <= STAT_ADDR;
                            arvalid_q  <= 1'b1;
                            state_q    <= StStatAr;
                        end
`else
                        end else begin
                            araddr_q  <= STAT_ADDR;
                            arvalid_q <= 1'b1;
                            state_q   <= StStatAr;
                        end
`endif
                    end
                end
                StDataAr: begin
                    if (bus.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StDataR;
                    end
                end
                StDataR: begin
                    if (bus.RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_rdata_q <= bus.RDATA[7:0];
                        err_q       <= (bus.RRESP != 2'b00);
                        state_q     <= StDone;
                    end
                end
                StWrAwW: begin
                    // AW and W retire independently, in either order
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                        bready_q <= 1'b1;
                        state_q  <= StWrB;
                    end
                end
                StWrB: begin
                    if (bus.BVALID) begin
                        bready_q <= 1'b0;
                        err_q    <= (bus.BRESP != 2'b00);
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.REQ_READY = req_ready_q;
    assign bus.BUSY      = busy_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.ARADDR    = araddr_q;
    assign bus.ARVALID   = arvalid_q;
    assign bus.RREADY    = rready_q;
    assign bus.AWADDR    = awaddr_q;
    assign bus.AWVALID   = awvalid_q;
    assign bus.WDATA     = wdata_q;
    assign bus.WSTRB     = wstrb_q;
    assign bus.WVALID    = wvalid_q;
    assign bus.BREADY    = bready_q;

endmodule

// File: tb/tb_core_uart_ctrl.sv
// tb_core_uart_ctrl: directed bench for core_uart_ctrl. A small AXI4-Lite UART model
// answers status/data reads from queues; each request pushes its hand-computed response
// into a scoreboard which a separate monitor pops on every RSP_VALID.
module tb_core_uart_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    core_uart_ctrl_if bus ();

    core_uart_ctrl #(
        .POLL_MAX (4)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Free-running cycle counter for latency measurement
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   accept_cyc = 0;
    int   rsp_count  = 0;

    // UART slave model configuration and observations
    logic [31:0] stat_q[$];
    logic [31:0] rx_word    = 32'h0;
    logic [1:0]  stat_rresp = 2'b00;
    logic [1:0]  data_rresp = 2'b00;
    logic [1:0]  bresp_cfg  = 2'b00;
    int          aw_delay   = 0;
    int          w_delay    = 0;
    int          stat_reads = 0;
    int          data_reads = 0;
    int          aw_cnt     = 0;
    int          w_cnt      = 0;
    logic [3:0]  ar_log[$];
    logic [3:0]  awaddr_seen = 4'h0;
    logic [31:0] wdata_seen  = 32'h0;
    logic [3:0]  wstrb_seen  = 4'h0;
    bit          split_seen  = 1'b0;
    int          viol        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        stat_reads = 0;
        data_reads = 0;
        aw_cnt     = 0;
        w_cnt      = 0;
        split_seen = 1'b0;
        ar_log.delete();
    endtask

    // Scoreboard monitor: compares every response pulse against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.RSP_VALID === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got RSP_VALID=1, expected none");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", {24'h0, bus.RSP_RDATA}, {24'h0, e.rdata});
                    check("rsp_err", {31'h0, bus.RSP_ERR}, {31'h0, e.err});
                    if (e.lat >= 0) check("rsp_latency", cyc - accept_cyc, e.lat);
                end
                rsp_count++;
            end
        end
    end

    // AXI4-Lite UART model: handshakes sampled at negedge, responses driven 1 after posedge
    initial begin
        logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [3:0] ar_addr;
        bit         aw_done, w_done, p_ar, p_aw, p_w;
        logic [3:0] p_araddr;
        int         aw_wait, w_wait;
        aw_done = 0; w_done = 0; p_ar = 0; p_aw = 0; p_w = 0; p_araddr = 0;
        aw_wait = 0; w_wait = 0; ar_addr = 0;
        bus.ARREADY = 1'b1;
        bus.RVALID  = 1'b0;
        bus.RDATA   = 32'h0;
        bus.RRESP   = 2'b00;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.BRESP   = 2'b00;
        forever begin
            @(negedge CLK);
            ar_hs = bus.ARVALID && bus.ARREADY;
            r_hs  = bus.RVALID && bus.RREADY;
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            b_hs  = bus.BVALID && bus.BREADY;
            // A valid raised last cycle without handshake must still be up and stable
            if (p_ar && (!bus.ARVALID || bus.ARADDR != p_araddr)) viol++;
            if (p_aw && !bus.AWVALID) viol++;
            if (p_w && !bus.WVALID) viol++;
            p_ar = bus.ARVALID && !ar_hs;
            p_aw = bus.AWVALID && !aw_hs;
            p_w  = bus.WVALID && !w_hs;
            p_araddr = bus.ARADDR;
            if (ar_hs) ar_addr = bus.ARADDR;
            if (aw_hs) begin awaddr_seen = bus.AWADDR; aw_cnt++; end
            if (w_hs) begin wdata_seen = bus.WDATA; wstrb_seen = bus.WSTRB; w_cnt++; end
            @(posedge CLK);
            #1;
            if (RST) begin
                bus.RVALID = 1'b0; bus.BVALID = 1'b0;
                bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
                aw_done = 0; w_done = 0; p_ar = 0; p_aw = 0; p_w = 0;
                aw_wait = 0; w_wait = 0;
            end else begin
                if (r_hs) bus.RVALID = 1'b0;
                if (b_hs) bus.BVALID = 1'b0;
                if (ar_hs) begin
                    ar_log.push_back(ar_addr);
                    bus.RVALID = 1'b1;
                    if (ar_addr == 4'h8) begin
                        stat_reads++;
                        bus.RDATA = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
                        bus.RRESP = stat_rresp;
                    end else begin
                        data_reads++;
                        bus.RDATA = rx_word;
                        bus.RRESP = data_rresp;
                    end
                end
                if (aw_hs) aw_done = 1;
                if (w_hs) w_done = 1;
                if (aw_done && w_done) begin
                    bus.BVALID = 1'b1;
                    bus.BRESP  = bresp_cfg;
                    aw_done = 0;
                    w_done  = 0;
                end
                if (bus.AWVALID) aw_wait++; else aw_wait = 0;
                if (bus.WVALID) w_wait++; else w_wait = 0;
                bus.AWREADY = bus.AWVALID && (aw_wait > aw_delay);
                bus.WREADY  = bus.WVALID && (w_wait > w_delay);
                if (!bus.AWVALID && bus.WVALID) split_seen = 1'b1;
            end
        end
    end

    // Issue one request, queue its expected response, wait (bounded) for completion
    task automatic do_req(input logic wr, input logic [7:0] wd, input logic [7:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        exp_t e;
        int   n;
        int   start_rsp;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        exp_q.push_back(e);
        start_rsp = rsp_count;
        @(negedge CLK);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = wr;
        bus.REQ_WDATA = wd;
        n = 0;
        while (bus.REQ_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (bus.REQ_READY !== 1'b1) begin
            bad++;
            $display("FAIL req_accept: got REQ_READY=%b after 50 cycles, expected 1", bus.REQ_READY);
            bus.REQ_VALID = 1'b0;
            exp_q.delete();
            return;
        end
        @(posedge CLK);
        #1;
        accept_cyc    = cyc;
        bus.REQ_VALID = 1'b0;
        n = 0;
        while (rsp_count == start_rsp && n < 500) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (rsp_count == start_rsp) begin
            bad++;
            $display("FAIL rsp_timeout: got no RSP_VALID in 500 cycles, expected one");
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WRITE = 1'b0;
        bus.REQ_WDATA = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Reset state
        check("rst_req_ready", {31'h0, bus.REQ_READY}, 32'h1);
        check("rst_busy", {31'h0, bus.BUSY}, 32'h0);
        check("rst_valids", {28'h0, bus.ARVALID, bus.AWVALID, bus.WVALID, bus.RSP_VALID}, 32'h0);
        check("rst_readys", {30'h0, bus.RREADY, bus.BREADY}, 32'h0);
        check("rst_addrs", {24'h0, bus.ARADDR, bus.AWADDR}, 32'h0);
        check("rst_wdata", bus.WDATA, 32'h0);
        check("rst_wstrb", {28'h0, bus.WSTRB}, 32'h1);
        check("rst_rsp", {23'h0, bus.RSP_ERR, bus.RSP_RDATA}, 32'h0);

        // Read, ready on first poll, zero-wait: RSP_VALID 5 edges after accept
        clear_log();
        stat_q = '{32'h1};
        rx_word = 32'h41;
        do_req(1'b0, 8'h00, 8'h41, 1'b0, 5);
        check("t1_ar_count", ar_log.size(), 2);
        if (ar_log.size() == 2) begin
            check("t1_ar0", {28'h0, ar_log[0]}, 32'h8);
            check("t1_ar1", {28'h0, ar_log[1]}, 32'h0);
        end

        // Read after three empty polls
        clear_log();
        stat_q = '{32'h0, 32'h0, 32'h0, 32'h1};
        rx_word = 32'hFFFF_FF7F;
        do_req(1'b0, 8'h00, 8'h7F, 1'b0, -1);
        check("t2_stat_reads", stat_reads, 4);
        check("t2_data_reads", data_reads, 1);

        // Write with TX full twice, AW accepted two cycles before W; RSP_RDATA unchanged
        clear_log();
        stat_q = '{32'h8, 32'h8, 32'h0};
        aw_delay = 0;
        w_delay = 2;
        do_req(1'b1, 8'h5A, 8'h7F, 1'b0, -1);
        check("t3_stat_reads", stat_reads, 3);
        check("t3_awaddr", {28'h0, awaddr_seen}, 32'h4);
        check("t3_wdata", wdata_seen, 32'h0000_005A);
        check("t3_wstrb", {28'h0, wstrb_seen}, 32'h1);
        check("t3_split", {31'h0, split_seen}, 32'h1);
        check("t3_aw_w_cnt", {aw_cnt[15:0], w_cnt[15:0]}, 32'h0001_0001);
        w_delay = 0;

        // Write with SLVERR response, then a normal read is accepted
        clear_log();
        stat_q = '{32'h0};
        bresp_cfg = 2'b10;
        do_req(1'b1, 8'h01, 8'h7F, 1'b1, 5);
        bresp_cfg = 2'b00;
        stat_q = '{32'h1};
        rx_word = 32'h11;
        do_req(1'b0, 8'h00, 8'h11, 1'b0, 5);

        // Status read error aborts the read without touching RX
        clear_log();
        stat_q = '{32'h1};
        stat_rresp = 2'b10;
        do_req(1'b0, 8'h00, 8'h11, 1'b1, -1);
        stat_rresp = 2'b00;
        check("t5_data_reads", data_reads, 0);

        // Reset while stuck in the AW/W phase
        clear_log();
        stat_q = '{32'h0};
        aw_delay = 100;
        w_delay = 100;
        @(negedge CLK);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = 1'b1;
        bus.REQ_WDATA = 8'h77;
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        n = 0;
        while (bus.AWVALID !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("t6_awvalid_pre", {31'h0, bus.AWVALID}, 32'h1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #2;
        check("t6_req_ready", {31'h0, bus.REQ_READY}, 32'h1);
        check("t6_busy", {31'h0, bus.BUSY}, 32'h0);
        check("t6_aw_w_valid", {30'h0, bus.AWVALID, bus.WVALID}, 32'h0);
        check("t6_rsp_valid", {31'h0, bus.RSP_VALID}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        aw_delay = 0;
        w_delay = 0;

        // Normal read after the reset; RSP_RDATA had been cleared by reset
        clear_log();
        stat_q = '{32'h1};
        rx_word = 32'hA5;
        do_req(1'b0, 8'h00, 8'hA5, 1'b0, 5);

        // Never-ready status
        clear_log();
`ifdef UART_CTRL_TIMEOUT_EN
        stat_q.delete();
        do_req(1'b0, 8'h00, 8'h00, 1'b1, -1);
        check("t8_stat_reads", stat_reads, 4);
        check("t8_data_reads", data_reads, 0);
`else
        stat_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
        rx_word = 32'h33;
        do_req(1'b0, 8'h00, 8'h33, 1'b0, -1);
        check("t8_stat_reads", stat_reads, 7);
        check("t8_data_reads", data_reads, 1);
`endif

        repeat (3) @(negedge CLK);
        check("axi_valid_rules", viol, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global bound on run time
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
